icache_ctrl: RTL and testbench

- Direct-mapped, read-only instruction cache controller between the core's fetch port and the 64-word distributed-ROM instruction memory.
- Memory is asynchronous-read: address in, data the same cycle.
- On a hit, fetch is served combinationally from the tag/data arrays. On a miss, the fetch stalls while an FSM refills the whole line from memory, one word per cycle.

---
 rtl/icache_pkg.sv | 41 ++++
 rtl/icache_line_store.sv | 90 +++++++++
 rtl/icache_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_icache_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the direct-mapped instruction cache controller:
//   - default geometry (address/data widths, line size, line count)
//   - derived field widths (offset / index / tag)
//   - FSM state encoding (IDLE, FILL)
//   - helpers that split a word address into tag, index and offset
// -----------------------------------------------------------------------------
package icache_pkg;

   localparam int DEF_ADDR_W     = 6;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_LINE_WORDS = 4;
   localparam int DEF_NUM_LINES  = 4;

   localparam int DEF_OFF_W = $clog2(DEF_LINE_WORDS);
   localparam int DEF_IDX_W = $clog2(DEF_NUM_LINES);
   localparam int DEF_TAG_W = DEF_ADDR_W - DEF_IDX_W - DEF_OFF_W;

   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE = 1'b0;
   localparam state_t ST_FILL = 1'b1;

   // Word offset inside a line: the low off_w bits.
   function automatic logic [31:0] addr_off(input logic [31:0] addr, input int off_w);
      return addr & ((32'd1 << off_w) - 32'd1);
   endfunction

   // Line index: idx_w bits directly above the offset.
   function automatic logic [31:0] addr_idx(input logic [31:0] addr, input int off_w,
                                            input int idx_w);
      return (addr >> off_w) & ((32'd1 << idx_w) - 32'd1);
   endfunction

   // Tag: everything above offset and index.
   function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int off_w,
                                            input int idx_w);
      return addr >> (off_w + idx_w);
   endfunction

endpackage

// File: rtl/icache_line_store.sv
// -----------------------------------------------------------------------------
// icache_line_store
// Data, tag and valid arrays of the direct-mapped instruction cache.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset (valid only)
//   rd_idx, rd_off           asynchronous read address (line, word)
//   rd_valid, rd_tag, rd_data  read results for hit detection and fetch data
//   wr_en, wr_idx, wr_off, wr_data  one-word-per-cycle refill write port
//   tag_wr_en, tag_wr_idx, tag_wr_tag  tag update; also marks the line valid
//   inv_all                  clears every valid bit on the next edge
// Data and tag arrays are deliberately not reset; only valid bits are.
// -----------------------------------------------------------------------------
module icache_line_store #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 2,
   parameter int IDX_W  = 2,
   parameter int OFF_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  rd_idx,
   input  logic [OFF_W-1:0]  rd_off,
   output logic              rd_valid,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [OFF_W-1:0]  wr_off,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              tag_wr_en,
   input  logic [IDX_W-1:0]  tag_wr_idx,
   input  logic [TAG_W-1:0]  tag_wr_tag,
   input  logic              inv_all
);

   localparam int NL = 1 << IDX_W;
   localparam int LW = 1 << OFF_W;

   logic [NL-1:0][LW-1:0][DATA_W-1:0] data_q, data_d;
   logic [NL-1:0][TAG_W-1:0]          tag_q, tag_d;
   logic [NL-1:0]                     valid_q, valid_d;

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_data  = data_q[rd_idx][rd_off];

   // Next-state of the data and tag arrays: single word / single tag write.
   always_comb begin
      data_d = data_q;
      tag_d  = tag_q;
      if (wr_en) begin
         data_d[wr_idx][wr_off] = wr_data;
      end else begin
         data_d = data_q;
      end
      if (tag_wr_en) begin
         tag_d[tag_wr_idx] = tag_wr_tag;
      end else begin
         tag_d = tag_q;
      end
   end

   // Next-state of valid bits: global invalidate wins over a line validate.
   always_comb begin
      valid_d = valid_q;
      if (inv_all) begin
         valid_d = {NL{1'b0}};
      end else if (tag_wr_en) begin
         valid_d[tag_wr_idx] = 1'b1;
      end else begin
         valid_d = valid_q;
      end
   end

   // Storage arrays without reset.
   always_ff @(posedge clk) begin
      data_q <= data_d;
      tag_q  <= tag_d;
   end

   // Valid bits with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= {NL{1'b0}};
      end else begin
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/icache_ctrl.sv
// -----------------------------------------------------------------------------
// icache_ctrl
// Direct-mapped, read-only instruction cache between the fetch port and an
// asynchronous-read instruction ROM. Hits are served combinationally; a miss
// stalls while the FSM refills the whole line, one word per cycle.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cpu_req, cpu_addr   fetch request and word address
//   cpu_rdata           instruction (0 unless cpu_ready)
//   cpu_ready           hit, data valid this cycle
//   cpu_stall           cpu_req & ~cpu_ready
//   flush               invalidate all lines, abort an in-progress fill
//   mem_addr, mem_rdata instruction memory address / data
//   mem_en              refill read active
//   hit_cnt, miss_cnt   saturating statistics counters
// Build option: ICACHE_STATS_EN enables the counters; otherwise they read 0.
// -----------------------------------------------------------------------------
module icache_ctrl
   import icache_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int NUM_LINES  = DEF_NUM_LINES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              cpu_stall,
   input  logic              flush,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_en,
   output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt
);

   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
   localparam logic [OFF_W-1:0] CNT_ONE  = OFF_W'(1);
   localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(LINE_WORDS - 1);

   state_t            state_q, state_d;
   logic [OFF_W-1:0]  cnt_q, cnt_d;
   logic [TAG_W-1:0]  fill_tag_q, fill_tag_d;
   logic [IDX_W-1:0]  fill_idx_q, fill_idx_d;

   logic [OFF_W-1:0]  addr_off_s;
   logic [IDX_W-1:0]  addr_idx_s;
   logic [TAG_W-1:0]  addr_tag_s;
   logic              rd_valid_s;
   logic [TAG_W-1:0]  rd_tag_s;
   logic [DATA_W-1:0] rd_data_s;
   logic              hit_s;
   logic              start_fill_s;
   logic              wr_en_s;
   logic              tag_wr_en_s;

   assign addr_off_s = OFF_W'(addr_off(32'(cpu_addr), OFF_W));
   assign addr_idx_s = IDX_W'(addr_idx(32'(cpu_addr), OFF_W, IDX_W));
   assign addr_tag_s = TAG_W'(addr_tag(32'(cpu_addr), OFF_W, IDX_W));

   icache_line_store #(
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W),
      .IDX_W  (IDX_W),
      .OFF_W  (OFF_W)
   ) u_store (
      .clk        (clk),
      .rst        (rst),
      .rd_idx     (addr_idx_s),
      .rd_off     (addr_off_s),
      .rd_valid   (rd_valid_s),
      .rd_tag     (rd_tag_s),
      .rd_data    (rd_data_s),
      .wr_en      (wr_en_s),
      .wr_idx     (fill_idx_q),
      .wr_off     (cnt_q),
      .wr_data    (mem_rdata),
      .tag_wr_en  (tag_wr_en_s),
      .tag_wr_idx (fill_idx_q),
      .tag_wr_tag (fill_tag_q),
      .inv_all    (flush)
   );

   // Hit detection and fetch-side outputs; no hit-under-miss while filling.
   always_comb begin
      hit_s = (state_q == ST_IDLE) && cpu_req && rd_valid_s && (rd_tag_s == addr_tag_s);
      cpu_ready = hit_s;
      cpu_stall = cpu_req && !hit_s;
      if (hit_s) begin
         cpu_rdata = rd_data_s;
      end else begin
         cpu_rdata = {DATA_W{1'b0}};
      end
   end

   // Refill FSM: flush beats both a new miss and an in-progress fill.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      fill_tag_d   = fill_tag_q;
      fill_idx_d   = fill_idx_q;
      start_fill_s = 1'b0;
      wr_en_s      = 1'b0;
      tag_wr_en_s  = 1'b0;
      mem_en       = 1'b0;
      mem_addr     = {ADDR_W{1'b0}};
      case (state_q)
         ST_IDLE: begin
            if (cpu_req && !hit_s && !flush) begin
               start_fill_s = 1'b1;
               fill_tag_d   = addr_tag_s;
               fill_idx_d   = addr_idx_s;
               cnt_d        = {OFF_W{1'b0}};
               state_d      = ST_FILL;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FILL: begin
            mem_en   = 1'b1;
            mem_addr = {fill_tag_q, fill_idx_q, cnt_q};
            if (flush) begin
               cnt_d   = {OFF_W{1'b0}};
               state_d = ST_IDLE;
            end else begin
               wr_en_s = 1'b1;
               cnt_d   = cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  tag_wr_en_s = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  state_d = ST_FILL;
               end
            end
         end
         default: begin
            cnt_d   = {OFF_W{1'b0}};
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM and fill-address registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= {OFF_W{1'b0}};
         fill_tag_q <= {TAG_W{1'b0}};
         fill_idx_q <= {IDX_W{1'b0}};
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         fill_tag_q <= fill_tag_d;
         fill_idx_q <= fill_idx_d;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [15:0] hit_cnt_q, hit_cnt_d;
   logic [15:0] miss_cnt_q, miss_cnt_d;

   // Saturating hit/miss counters; flush does not touch them.
   always_comb begin
      if (hit_s && (hit_cnt_q != 16'hFFFF)) begin
         hit_cnt_d = hit_cnt_q + 16'd1;
      end else begin
         hit_cnt_d = hit_cnt_q;
      end
      if (start_fill_s && (miss_cnt_q != 16'hFFFF)) begin
         miss_cnt_d = miss_cnt_q + 16'd1;
      end else begin
         miss_cnt_d = miss_cnt_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_q  <= 16'd0;
         miss_cnt_q <= 16'd0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`else
   assign hit_cnt  = 16'd0;
   assign miss_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_ctrl
// Scoreboard bench for icache_ctrl: stimulus pushes the expected fetch data and
// the expected refill addresses; a negedge monitor pops and compares them
// whenever the DUT presents cpu_ready or mem_en.
// -----------------------------------------------------------------------------
module tb_icache_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req = 1'b0;
   logic [5:0]  cpu_addr = 6'd0;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        cpu_stall;
   logic        flush = 1'b0;
   logic [5:0]  mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_en;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_rdata_q[$];
   logic [5:0]  exp_maddr_q[$];

   always #5 clk = ~clk;

   // Instruction ROM contents: word a holds 0xC0DE0000 + a*0x111.
   function automatic logic [31:0] rom(input logic [5:0] a);
      return 32'hC0DE_0000 + 32'(a) * 32'h0000_0111;
   endfunction

   assign mem_rdata = rom(mem_addr);

   icache_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_addr  (cpu_addr),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .cpu_stall (cpu_stall),
      .flush     (flush),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .mem_en    (mem_en),
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Monitor: compare against scoreboard whenever the DUT presents data or a refill read.
   always @(negedge clk) begin
      if (!rst) begin
         if (cpu_ready) begin
            if (exp_rdata_q.size() == 0) chk("unexpected_ready", 32'd1, 32'd0);
            else chk("cpu_rdata", cpu_rdata, exp_rdata_q.pop_front());
         end else begin
            chk("rdata_zero_when_not_ready", cpu_rdata, 32'd0);
         end
         if (mem_en) begin
            if (exp_maddr_q.size() == 0) chk("unexpected_mem_en", 32'd1, 32'd0);
            else chk("mem_addr", 32'(mem_addr), 32'(exp_maddr_q.pop_front()));
         end else begin
            chk("idle_mem_addr_zero", 32'(mem_addr), 32'd0);
         end
         chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~cpu_ready));
      end
   end

   // Issue one fetch and measure cycles until cpu_ready; a miss expects a full refill.
   task automatic fetch(input logic [5:0] a, input int exp_lat, input string nm);
      int lat;
      lat = 0;
      if (exp_lat > 0) begin
         for (int k = 0; k < 4; k++) exp_maddr_q.push_back({a[5:2], 2'(k)});
      end
      exp_rdata_q.push_back(rom(a));
      cpu_req  = 1'b1;
      cpu_addr = a;
      @(negedge clk);
      while (!cpu_ready && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk(nm, 32'(lat), 32'(exp_lat));
      @(posedge clk); #1;
      cpu_req = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
      chk("rst_cpu_rdata", cpu_rdata, 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
      chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      next_cycle();

      // Cold miss, spatial hits, conflict eviction
      fetch(6'h05, 5, "cold_miss_latency");
      fetch(6'h07, 0, "spatial_hit_latency");
      fetch(6'h04, 0, "spatial_hit2_latency");
      fetch(6'h15, 5, "conflict_miss_latency");
      fetch(6'h16, 0, "conflict_hit_latency");
      fetch(6'h05, 5, "evicted_remiss_latency");

      // Flush in the 2nd FILL cycle aborts the refill of 0x20
      exp_maddr_q.push_back(6'h20);
      exp_maddr_q.push_back(6'h21);
      cpu_req = 1'b1; cpu_addr = 6'h20;
      next_cycle();                 // FILL cycle 1
      next_cycle();                 // FILL cycle 2
      flush = 1'b1; cpu_req = 1'b0;
      next_cycle();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_abort_idle", 32'(mem_en), 32'd0);
      next_cycle();
      fetch(6'h20, 5, "after_flush_remiss_latency");

      // Flush with same-cycle hit: served now, invalid afterwards
      exp_rdata_q.push_back(rom(6'h21));
      cpu_req = 1'b1; cpu_addr = 6'h21; flush = 1'b1;
      @(negedge clk);
      chk("flush_hit_served", 32'(cpu_ready), 32'd1);
      next_cycle();
      flush = 1'b0; cpu_req = 1'b0;
      fetch(6'h21, 5, "flush_hit_then_miss_latency");

      // Flush beats a simultaneous miss: no refill starts
      cpu_req = 1'b1; cpu_addr = 6'h30; flush = 1'b1;
      next_cycle();
      flush = 1'b0; cpu_req = 1'b0;
      @(negedge clk);
      chk("flush_blocks_miss", 32'(mem_en), 32'd0);
      next_cycle();
      fetch(6'h30, 5, "flush_priority_remiss_latency");

      // Reset mid-fill at cnt==2
      fetch(6'h05, 5, "reload_05_latency");
      exp_maddr_q.push_back(6'h08);
      exp_maddr_q.push_back(6'h09);
      cpu_req = 1'b1; cpu_addr = 6'h09;
      next_cycle();                 // cnt=0
      next_cycle();                 // cnt=1
      next_cycle();                 // cnt=2
      #1 rst = 1'b1;
      #1;
      chk("midfill_rst_mem_en", 32'(mem_en), 32'd0);
      chk("midfill_rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("midfill_rst_ready", 32'(cpu_ready), 32'd0);
      chk("midfill_rst_rdata", cpu_rdata, 32'd0);
      chk("midfill_refill_reads", 32'(exp_maddr_q.size()), 32'd0);
      cpu_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      next_cycle();
      fetch(6'h05, 5, "post_reset_remiss_latency");
      fetch(6'h06, 0, "stats_hit2_latency");
      fetch(6'h07, 0, "stats_hit3_latency");

`ifdef ICACHE_STATS_EN
      chk("miss_cnt", 32'(miss_cnt), 32'd1);
      chk("hit_cnt", 32'(hit_cnt), 32'd3);
      @(negedge clk);
      force dut.hit_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.hit_cnt_q;
      fetch(6'h04, 0, "sat_hit_latency");
      chk("hit_cnt_saturated", 32'(hit_cnt), 32'h0000_FFFF);
`else
      chk("miss_cnt_tied", 32'(miss_cnt), 32'd0);
      chk("hit_cnt_tied", 32'(hit_cnt), 32'd0);
`endif

      repeat (2) next_cycle();
      chk("rdata_queue_drained", 32'(exp_rdata_q.size()), 32'd0);
      chk("maddr_queue_drained", 32'(exp_maddr_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
